// File: rtl/comet2_loader_pkg.sv
// ---------------------------------------------------------------------------
// comet2_loader_pkg : shared types and constants for the COMET II loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package comet2_loader_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_ADDR_H = 4'd1,
      ST_ADDR_L = 4'd2,
      ST_CNT_H  = 4'd3,
      ST_CNT_L  = 4'd4,
      ST_DATA_H = 4'd5,
      ST_DATA_L = 4'd6,
      ST_CSUM   = 4'd7,
      ST_DONE   = 4'd8,
      ST_ERROR  = 4'd9
   } state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_CSUM = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Frame body: everything between SYNC detection and the terminal states.
   function automatic logic in_frame(input state_t s);
      return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERROR);
   endfunction

   function automatic logic takes_bytes(input state_t s);
      return (s != ST_DONE) && (s != ST_ERROR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/comet2_loader_timeout.sv
// ---------------------------------------------------------------------------
// comet2_loader_timeout : reloadable inter-byte watchdog for the loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module comet2_loader_timeout #(
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic mclk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic expire
);

   generate
      if (TIMEOUT == 16'd0) begin : g_tmo_off
         logic unused_tmo;
         assign unused_tmo = ^{mclk, rst_n, enable, clear};
         assign expire     = 1'b0;
      end else begin : g_tmo_on
         logic [15:0] cnt_q;
         logic [15:0] cnt_d;

         // Reload whenever idle or a byte is taken; otherwise count down.
         always_comb begin
            cnt_d = cnt_q;
            if (!enable || clear) begin
               cnt_d = TIMEOUT;
            end else if (cnt_q != 16'd0) begin
               cnt_d = cnt_q - 16'd1;
            end
         end

         always_ff @(posedge mclk) begin
            if (!rst_n) begin
               cnt_q <= TIMEOUT;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         // Fires on the TIMEOUT-th consecutive edge without an accept.
         assign expire = enable & ~clear & (cnt_q == 16'd1);
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/comet2_prog_loader.sv
// ---------------------------------------------------------------------------
// comet2_prog_loader : framed host byte stream to program RAM write port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module comet2_prog_loader
   import comet2_loader_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
   parameter logic [15:0] TIMEOUT   = 16'd50000
) (
   input  logic        mclk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        clr,
   output logic        we,
   output logic [15:0] waddr,
   output logic [15:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic        cpu_hold
);

   state_t      state_q, state_d;
   logic [7:0]  sum_q, sum_d;
   logic [15:0] ptr_q, ptr_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  hi_q, hi_d;
   logic        we_q, we_d;
   logic [15:0] waddr_q, waddr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [1:0]  err_code_q, err_code_d;
   logic        in_ready_q, in_ready_d;

   logic        accept;
   logic [7:0]  sum_acc;
   logic        tmo_expire;

   assign accept  = in_valid & in_ready_q;
   assign sum_acc = sum_q + in_data;

   comet2_loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .mclk    (mclk),
      .rst_n   (rst_n),
      .enable  (in_frame(state_q)),
      .clear   (accept),
      .expire  (tmo_expire)
   );

   always_comb begin
      state_d    = state_q;
      sum_d      = sum_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      err_code_d = err_code_q;

      if (accept && in_frame(state_q)) begin
         sum_d = sum_acc;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (accept && (in_data == SYNC_BYTE)) begin
               state_d = ST_ADDR_H;
               sum_d   = 8'h00;
            end
         end
         ST_ADDR_H: begin
            if (accept) begin
               ptr_d[15:8] = in_data;
               state_d     = ST_ADDR_L;
            end
         end
         ST_ADDR_L: begin
            if (accept) begin
               ptr_d[7:0] = in_data;
               state_d    = ST_CNT_H;
            end
         end
         ST_CNT_H: begin
            if (accept) begin
               cnt_d[15:8] = in_data;
               state_d     = ST_CNT_L;
            end
         end
         ST_CNT_L: begin
            if (accept) begin
               cnt_d[7:0] = in_data;
               state_d    = ({cnt_q[15:8], in_data} == 16'd0) ? ST_CSUM : ST_DATA_H;
            end
         end
         ST_DATA_H: begin
            if (accept) begin
               hi_d    = in_data;
               state_d = ST_DATA_L;
            end
         end
         ST_DATA_L: begin
            // Write port is registered, so a hi byte taken during the we
            // cycle only touches hi_q and leaves waddr/wdata untouched.
            if (accept) begin
               we_d    = 1'b1;
               waddr_d = ptr_q;
               wdata_d = {hi_q, in_data};
               ptr_d   = ptr_q + 16'd1;
               cnt_d   = cnt_q - 16'd1;
               state_d = (cnt_q == 16'd1) ? ST_CSUM : ST_DATA_H;
            end
         end
         ST_CSUM: begin
            if (accept) begin
               if (sum_acc == 8'h00) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_CSUM;
               end
            end
         end
         ST_DONE, ST_ERROR: begin
            if (clr) begin
               state_d    = ST_IDLE;
               err_code_d = ERR_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Expire is already gated off by an accept in the same cycle.
      if (tmo_expire && in_frame(state_q)) begin
         state_d    = ST_ERROR;
         err_code_d = ERR_TMO;
      end

      in_ready_d = takes_bytes(state_d);
   end

   always_ff @(posedge mclk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sum_q      <= 8'h00;
         ptr_q      <= 16'h0000;
         cnt_q      <= 16'h0000;
         hi_q       <= 8'h00;
         we_q       <= 1'b0;
         waddr_q    <= 16'h0000;
         wdata_q    <= 16'h0000;
         err_code_q <= ERR_NONE;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sum_q      <= sum_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         err_code_q <= err_code_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready = in_ready_q;
   assign we       = we_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign busy     = in_frame(state_q);
   assign done     = (state_q == ST_DONE);
   assign err      = (state_q == ST_ERROR);
   assign err_code = err_code_q;
   assign cpu_hold = (state_q != ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_comet2_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_comet2_prog_loader : directed self-checking bench for comet2_prog_loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_comet2_prog_loader;

   logic        mclk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        clr;
   logic        we;
   logic [15:0] waddr;
   logic [15:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic        cpu_hold;

   int total = 0;
   int bad   = 0;

   int          wtot = 0;
   logic [15:0] wa [0:15];
   logic [15:0] wd [0:15];

   always #5 mclk = ~mclk;

   comet2_prog_loader #(
      .SYNC_BYTE (8'hA5),
      .TIMEOUT   (16'd8)
   ) dut (
      .mclk     (mclk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .clr      (clr),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_code (err_code),
      .cpu_hold (cpu_hold)
   );

   // RAM-side capture: records every write the way a negedge RAM would.
   always @(negedge mclk) begin
      if (we === 1'b1 && wtot < 16) begin
         wa[wtot] = waddr;
         wd[wtot] = wdata;
         wtot     = wtot + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge mclk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic pulse_clr();
      in_valid = 1'b0;
      clr      = 1'b1;
      @(posedge mclk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      clr      = 1'b0;

      // Reset values
      repeat (3) @(posedge mclk);
      @(negedge mclk);
      chk("rst_flags", {in_ready, we, busy, done, err, err_code, cpu_hold}, 32'b0000_0001);
      chk("rst_waddr", waddr, 16'h0000);
      chk("rst_wdata", wdata, 16'h0000);
      @(posedge mclk);
      #1 rst_n = 1'b1;
      @(negedge mclk);
      chk("rdy_still_low", in_ready, 1'b0);
      @(posedge mclk);
      #1;
      chk("rdy_rises", in_ready, 1'b1);

      // Frame A, good checksum (sum of body = D0, CSUM = 30)
      base = wtot;
      send_byte(8'hA5);
      chk("a_busy", {busy, cpu_hold}, 2'b11);
      send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34);
      chk("a_we1", {we, waddr, wdata}, {1'b1, 16'h0010, 16'h1234});
      send_byte(8'hAB);
      chk("a_we_drop_hold", {we, waddr, wdata}, {1'b0, 16'h0010, 16'h1234});
      send_byte(8'hCD);
      chk("a_we2", {we, waddr, wdata}, {1'b1, 16'h0011, 16'hABCD});
      send_byte(8'h30);
      chk("a_done", {done, err, cpu_hold, in_ready, busy}, 5'b10000);
      idle(3);
      chk("a_nwrites", wtot - base, 2);
      chk("a_w0", {wa[base], wd[base]}, {16'h0010, 16'h1234});
      chk("a_w1", {wa[base+1], wd[base+1]}, {16'h0011, 16'hABCD});
      chk("a_sticky", {done, cpu_hold}, 2'b10);
      pulse_clr();
      chk("a_clr", {done, err, cpu_hold, in_ready}, 4'b0011);

      // Frame A, bad checksum
      base = wtot;
      send_byte(8'hA5);
      send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
      send_byte(8'h31);
      chk("b_err", {done, err, err_code, cpu_hold, in_ready}, 6'b01_01_10);
      idle(3);
      chk("b_nwrites", wtot - base, 2);
      chk("b_err_sticky", {err, err_code}, 3'b1_01);
      pulse_clr();
      chk("b_clr", {done, err, err_code, busy, in_ready, cpu_hold}, 7'b00_00_011);

      // Address wrap, count 2; a clr pulse mid-frame must be ignored
      base = wtot;
      send_byte(8'hA5);
      send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h02);
      clr = 1'b1;
      send_byte(8'h11);
      clr = 1'b0;
      chk("w_clr_ignored", {busy, in_ready}, 2'b11);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h22);
      send_byte(8'h9A);
      chk("w_done", {done, err}, 2'b10);
      idle(2);
      chk("w_nwrites", wtot - base, 2);
      chk("w_w0", {wa[base], wd[base]}, {16'hFFFF, 16'h1111});
      chk("w_w1", {wa[base+1], wd[base+1]}, {16'h0000, 16'h2222});
      pulse_clr();

      // Junk before SYNC, zero count
      base = wtot;
      send_byte(8'h00); send_byte(8'hFF);
      chk("z_junk_discarded", {busy, in_ready}, 2'b01);
      send_byte(8'hA5);
      send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
      chk("z_no_we", we, 1'b0);
      send_byte(8'hE0);
      chk("z_done", {done, err, cpu_hold}, 3'b100);
      idle(2);
      chk("z_nwrites", wtot - base, 0);
      pulse_clr();

      // Timeout after ADDR_L
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
      idle(7);
      chk("t_not_yet", {err, busy}, 2'b01);
      idle(1);
      chk("t_expired", {err, err_code, busy, cpu_hold, in_ready}, 6'b1_10_010);
      pulse_clr();
      chk("t_clr", {err, err_code}, 3'b0_00);

      // Same, but a byte lands on the eighth cycle
      base = wtot;
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34);
      idle(7);
      send_byte(8'h00);
      chk("t_rescued", {err, busy}, 2'b01);
      send_byte(8'h00);
      send_byte(8'hBA);
      chk("t_done", {done, err, err_code}, 4'b10_00);
      chk("t_nwrites", wtot - base, 0);
      pulse_clr();

      // Reset mid-frame after the first data word
      send_byte(8'hA5);
      send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34);
      chk("r_we_before", we, 1'b1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge mclk);
      #1 rst_n = 1'b1;
      chk("r_flags", {in_ready, we, busy, done, err, err_code, cpu_hold}, 32'b0000_0001);
      chk("r_bus", {waddr, wdata}, 32'h0000_0000);
      @(posedge mclk);
      #1;
      chk("r_rdy", in_ready, 1'b1);

      base = wtot;
      send_byte(8'hA5);
      send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
      send_byte(8'h30);
      chk("r2_done", {done, err, cpu_hold}, 3'b100);
      idle(2);
      chk("r2_nwrites", wtot - base, 2);
      chk("r2_w0", {wa[base], wd[base]}, {16'h0010, 16'h1234});
      chk("r2_w1", {wa[base+1], wd[base+1]}, {16'h0011, 16'hABCD});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
